// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   It drives the select/enable inputs of a 2-to-4 active-low digit decoder
//   and presents the hex nibble of the currently selected digit to the
//   segment encoder.
//
//   New values are staged in a pending register and only reach the display
//   at a frame boundary, so a frame never mixes old and new digits.
//
//   Each digit slot begins with a short blanking interval to avoid ghosting.
//   A digit can be suppressed by its mask bit or by leading-zero blanking.
//
// Ports
//   clk          system clock, rising edge
//   resetn       synchronous active-low reset
//   run          1 = scan, 0 = idle with all digits off
//   load         capture value_in this cycle
//   value_in     four hex digits, [3:0] = digit 0 ... [15:12] = digit 3
//   digit_mask   bit i enables digit i
//   lz_suppress  1 = blank leading zero digits (digit 0 is never blanked)
//   sel_a        digit index MSB (decoder A)
//   sel_b        digit index LSB (decoder B)
//   sel_en       decoder enable, 0 = all digits off
//   nibble       hex value of the selected digit
//   frame_done   one-cycle pulse when the digit 3 slot ends
module display_scan_ctrl #(
    parameter int DIV_WIDTH    = 16,
    parameter int DIV_MAX      = 49999,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  digit_mask,
    input  logic        lz_suppress,
    output logic        sel_a,
    output logic        sel_b,
    output logic        sel_en,
    output logic [3:0]  nibble,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    localparam logic [DIV_WIDTH-1:0] CNT_MAX    = DIV_WIDTH'(DIV_MAX);
    // With no blanking interval a slot starts directly in SHOW.
    localparam state_t               SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    state_t               state, state_nxt;
    logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
    logic [1:0]           idx, idx_nxt;
    logic [15:0]          disp_reg, disp_nxt;
    logic [15:0]          pend_reg, pend_nxt;
    logic                 pend_valid, pend_valid_nxt;
    logic                 frame_done_nxt;
    logic                 sel_en_nxt;
    logic [3:0]           nibble_nxt;

    // A digit is lit when its mask bit is set and it is not a leading zero.
    // Leading zero: digit i (i != 0) and every digit from i up to 3 is zero.
    function automatic logic digit_lit(input logic [1:0]  i,
                                       input logic [15:0] v,
                                       input logic [3:0]  mask,
                                       input logic        lz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(i) && v[4*j +: 4] != 4'h0) begin
                upper_zero = 1'b0;
            end
        end
        return mask[i] && !(lz && (i != 2'd0) && upper_zero);
    endfunction

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        idx_nxt        = idx;
        disp_nxt       = disp_reg;
        pend_nxt       = pend_reg;
        pend_valid_nxt = pend_valid;
        frame_done_nxt = 1'b0;

        if (load) begin
            pend_nxt       = value_in;
            pend_valid_nxt = 1'b1;
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                idx_nxt = 2'd0;
                // Nothing is being scanned, so a pending value can go straight in.
                if (pend_valid) begin
                    disp_nxt       = pend_reg;
                    pend_valid_nxt = load;
                end
                if (run) begin
                    state_nxt = SLOT_START;
                end
            end
            default: begin
                if (!run) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    idx_nxt   = 2'd0;
                end else if (cnt == CNT_MAX) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                    state_nxt = SLOT_START;
                    if (idx == 2'd3) begin
                        frame_done_nxt = 1'b1;
                        // Frame boundary commit; a load on this very edge wins.
                        if (load) begin
                            disp_nxt       = value_in;
                            pend_valid_nxt = 1'b0;
                        end else if (pend_valid) begin
                            disp_nxt       = pend_reg;
                            pend_valid_nxt = 1'b0;
                        end
                    end
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                    state_nxt = ((int'(cnt) + 1) >= BLANK_CYCLES) ? SHOW : BLANK;
                end
            end
        endcase

        // Outputs are registered from the next-state values so idx, nibble
        // and sel_en all change on the same edge.
        sel_en_nxt = (state_nxt == SHOW) &&
                     digit_lit(idx_nxt, disp_nxt, digit_mask, lz_suppress);
        nibble_nxt = disp_nxt[4*idx_nxt +: 4];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            disp_reg   <= 16'h0000;
            pend_reg   <= 16'h0000;
            pend_valid <= 1'b0;
            sel_a      <= 1'b0;
            sel_b      <= 1'b0;
            sel_en     <= 1'b0;
            nibble     <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            disp_reg   <= disp_nxt;
            pend_reg   <= pend_nxt;
            pend_valid <= pend_valid_nxt;
            sel_a      <= idx_nxt[1];
            sel_b      <= idx_nxt[0];
            sel_en     <= sel_en_nxt;
            nibble     <= nibble_nxt;
            frame_done <= frame_done_nxt;
        end
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller for a 4-digit seven-segment display. It sits directly upstream of the 2-to-4 active-low digit decoder: it generates the 2-bit digit select (A/B) and enable for that decoder, plus the 4-bit hex nibble for the currently selected digit, which goes to the segment encoder. It provides tear-free value updates, a per-slot blanking (anti-ghost) interval, a digit mask and leading-zero suppression.

Parameters:
DIV_WIDTH, 16, width of slot counter
DIV_MAX, 49999, terminal count; one digit slot = DIV_MAX+1 clk cycles
BLANK_CYCLES, 100, cycles at start of each slot with sel_en=0; must satisfy 0 <= BLANK_CYCLES <= DIV_MAX

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  synchronous active-low reset
run  input  1  1 = scan; 0 = idle/blank
load  input  1  capture value_in this cycle
value_in  input  16  four hex digits; [3:0] = digit 0 (least significant), [15:12] = digit 3
digit_mask  input  4  per-digit enable; bit i enables digit i
lz_suppress  input  1  1 = blank leading zero digits
sel_a  output  1  digit index MSB, drives decoder A
sel_b  output  1  digit index LSB, drives decoder B
sel_en  output  1  decoder enable; 0 = all digits off
nibble  output  4  hex value of the selected digit
frame_done  output  1  one-cycle pulse at end of digit 3 slot

Behaviour:
- One clock; reset is synchronous and active-low: clk rising edge with resetn=0 sets state=IDLE, cnt=0, idx=0, disp_reg=0, pend_reg=0, pend_valid=0, and all outputs to 0. resetn has priority over all other inputs, including mid-slot.
- All outputs are registered. {sel_a,sel_b}=idx, and nibble=disp_reg[4*idx+3:4*idx], updated on the same edge as idx.
- States: IDLE, BLANK, SHOW.
- IDLE: sel_en=0. If run=1 at an edge, go to BLANK with idx=0, cnt=0. If BLANK_CYCLES=0, go straight to SHOW.
- cnt increments every cycle while not in IDLE.
  - BLANK covers cnt 0..BLANK_CYCLES-1.
  - SHOW covers cnt BLANK_CYCLES..DIV_MAX.
  - sel_en=1 in SHOW only if the digit is not suppressed.
- At cnt==DIV_MAX: cnt<=0, idx<=idx+1 mod 4, state<=BLANK (or SHOW if BLANK_CYCLES=0).
- When idx==3 at terminal count: frame_done=1 for exactly that next cycle. If pend_valid, then disp_reg<=pend_reg and pend_valid<=0 (the frame-boundary commit).
- load=1: pend_reg<=value_in, pend_valid<=1. Back-to-back loads: last one wins.
- Commit special cases:
  - load on the commit cycle: disp_reg<=value_in directly, pend_valid<=0.
  - In IDLE, pending commits on the next edge (no tearing is possible).
- Suppression of digit i (evaluated on disp_reg):
  - digit_mask[i]=0; or
  - lz_suppress=1, i!=0, and nibbles i..3 are all zero.
  - A suppressed digit keeps sel_en=0 for the entire slot. Slot timing is unchanged.
- run=0 in BLANK or SHOW: next edge goes to IDLE with sel_en=0, idx=0, cnt=0, frame_done=0. No partial frame_done is generated.
- The decoder must never see sel_en=1 while idx changes. idx changes only on an edge where sel_en goes or stays 0 (the slot boundary enters BLANK, or a suppressed/next-slot case). When BLANK_CYCLES=0, a one-cycle overlap is permitted.

Test Plan:
Bench parameters for all scenarios: DIV_MAX=9, BLANK_CYCLES=2.
1. Reset: resetn=0 for 3 cycles with run=1 and load=1 -> all outputs 0. Release -> first edge enters BLANK with idx=0; sel_en rises 2 cycles later.
2. Basic scan: in IDLE, load 0x1234, mask=4'hF, run=1 -> idx sequence 0,1,2,3 repeating, 10 cycles each. Each slot: sel_en=0 for 2 cycles, then 1 for 8. nibble sequence 4,3,2,1. frame_done pulses every 40 cycles.
3. Tear-free update: during digit 1 slot, load 0xABCD -> rest of frame still shows 3,2,1. Commit occurs with frame_done; next frame shows D,C,B,A. Also: load 0x5555 on the commit cycle itself -> next frame shows 5,5,5,5.
4. Leading zeros: lz_suppress=1, value 0x0050 -> digits 3 and 2 have sel_en=0 for the whole slot; digit 1 shows 5; digit 0 shows 0. Value 0x0000 -> only digit 0 lit. Value 0x0F00 with lz_suppress=0 -> all digits lit.
5. Mask: digit_mask=4'b1010 -> sel_en=1 only in idx 1 and 3 slots; period still 40 cycles.
6. Abort: drop run at cnt=5 of the digit 2 slot -> next cycle sel_en=0, idx=0, no frame_done. Raise run -> scan restarts at digit 0. Repeat the same abort with resetn=0 -> identical response, and pend_valid is cleared.
